// File: rtl/sram_responder_if.sv
// Instruction and data SRAM bus bundle between the core (master) and the
// on-chip memory responder (slave).
interface sram_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/sram_responder.sv
// Dual-port one-cycle-latency memory shared by instruction fetch and load/store.
// Define SRAM_WR_FWD_EN to forward a same-cycle data write to the instruction port.
module sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    sram_responder_if.slave  bus,
    output logic [CNT_W-1:0] oor_cnt,
    output logic             oor_flag
);

    localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;
    localparam logic [32:0] SPAN      = 33'd4 << ADDR_W;
    localparam int          WORDS     = 2 ** ADDR_W;

    logic [31:0] mem [WORDS];

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] phys;
        logic [31:0] off;
        phys = addr & PHYS_MASK;
        off  = phys - BASE_ADDR;
        return (phys >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr & PHYS_MASK) - BASE_ADDR;
        return ADDR_W'(off >> 2);
    endfunction

    logic              inst_ok;
    logic              data_ok;
    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              data_wr;
    logic [31:0]       data_merged;
    logic [31:0]       inst_word;
    logic              inst_err;
    logic              data_err;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;
    logic              unused_inst_wdata;

    assign unused_inst_wdata = ^bus.inst_sram_wdata;

    // Decode both ports and build the write-first word seen by the data port.
    always_comb begin
        inst_ok     = addr_in_range(bus.inst_sram_addr);
        data_ok     = addr_in_range(bus.data_sram_addr);
        inst_idx    = addr_word_idx(bus.inst_sram_addr);
        data_idx    = addr_word_idx(bus.data_sram_addr);
        data_wr     = bus.data_sram_en && (bus.data_sram_wen != 4'h0) && data_ok;

        data_merged = mem[data_idx];
        for (int b = 0; b < 4; b++) begin
            if (bus.data_sram_wen[b]) begin
                data_merged[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
            end
        end

        inst_word = mem[inst_idx];
`ifdef SRAM_WR_FWD_EN
        if (data_wr && (data_idx == inst_idx)) begin
            inst_word = data_merged;
        end
`endif

        inst_err = bus.inst_sram_en && ((bus.inst_sram_wen != 4'h0) || !inst_ok);
        data_err = bus.data_sram_en && !data_ok;

        // At most +2 per cycle, so any overflow shows up in the carry bit.
        cnt_sum  = {1'b0, oor_cnt} + (CNT_W+1)'(inst_err) + (CNT_W+1)'(data_err);
        cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // The array has no reset path: a store issued alongside rst still lands.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (data_wr && bus.data_sram_wen[b]) begin
                mem[data_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.inst_sram_rdata <= 32'h0;
            bus.data_sram_rdata <= 32'h0;
            oor_cnt             <= '0;
            oor_flag            <= 1'b0;
        end else begin
            if (bus.inst_sram_en) begin
                bus.inst_sram_rdata <= inst_ok ? inst_word : 32'h0;
            end
            if (bus.data_sram_en) begin
                bus.data_sram_rdata <= data_ok ? data_merged : 32'h0;
            end
            if (inst_err || data_err) begin
                oor_cnt  <= cnt_next;
                oor_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a word-level memory model and
// hand-computed checkpoints; build with SRAM_WR_FWD_EN to match the DUT build.
module tb_sram_responder;

    localparam int          ADDR_W    = 14;
    localparam logic [31:0] BASE_ADDR = 32'h1FC0_0000;
    localparam int          CNT_W     = 2;
    localparam longint      WORDS     = 64'd1 << ADDR_W;

`ifdef SRAM_WR_FWD_EN
    localparam logic FWD_BUILD = 1'b1;
`else
    localparam logic FWD_BUILD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] oor_cnt;
    logic             oor_flag;

    sram_responder_if bus ();

    sram_responder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .oor_cnt (oor_cnt),
        .oor_flag(oor_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: memory is a sparse map of fully known words; a word is unknown
    // until written with all four lanes, or partially on top of a known word.
    logic [31:0] model_mem [longint];
    logic        model_ready  = 1'b0;
    logic        exp_i_known  = 1'b0;
    logic        exp_d_known  = 1'b0;
    logic [31:0] exp_inst     = 32'h0;
    logic [31:0] exp_data     = 32'h0;
    int          exp_cnt      = 0;
    logic        exp_flag     = 1'b0;

    function automatic logic translate(input logic [31:0] addr, output longint idx);
        longint phys;
        phys = longint'(addr & 32'h1FFF_FFFF);
        idx  = (phys - longint'(BASE_ADDR)) / 4;
        return (phys >= longint'(BASE_ADDR)) && (phys < longint'(BASE_ADDR) + 4 * WORDS);
    endfunction

    always @(posedge clk) begin
        longint      i_idx;
        longint      d_idx;
        logic        i_ok;
        logic        d_ok;
        logic        d_write;
        logic        new_known;
        logic [31:0] new_word;
        logic [31:0] i_word;
        logic        i_known;
        int          errs;

        i_ok    = translate(bus.inst_sram_addr, i_idx);
        d_ok    = translate(bus.data_sram_addr, d_idx);
        d_write = bus.data_sram_en && bus.data_sram_wen != 4'h0 && d_ok;

        new_known = model_mem.exists(d_idx) || (bus.data_sram_wen == 4'hF);
        new_word  = model_mem.exists(d_idx) ? model_mem[d_idx] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (bus.data_sram_wen[b]) new_word[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];

        i_known = model_mem.exists(i_idx);
        i_word  = i_known ? model_mem[i_idx] : 32'h0;
        if (FWD_BUILD && d_write && d_idx == i_idx) begin
            i_known = new_known;
            i_word  = new_word;
        end

        if (rst) begin
            model_ready = 1'b1;
            exp_i_known = 1'b1;
            exp_d_known = 1'b1;
            exp_inst    = 32'h0;
            exp_data    = 32'h0;
            exp_cnt     = 0;
            exp_flag    = 1'b0;
        end else if (model_ready) begin
            errs = 0;
            if (bus.inst_sram_en) begin
                exp_i_known = i_ok ? i_known : 1'b1;
                exp_inst    = i_ok ? i_word  : 32'h0;
                if (bus.inst_sram_wen != 4'h0 || !i_ok) errs++;
            end
            if (bus.data_sram_en) begin
                if (!d_ok) begin
                    exp_d_known = 1'b1;
                    exp_data    = 32'h0;
                    errs++;
                end else if (bus.data_sram_wen != 4'h0) begin
                    exp_d_known = new_known;
                    exp_data    = new_word;
                end else begin
                    exp_d_known = model_mem.exists(d_idx);
                    exp_data    = exp_d_known ? model_mem[d_idx] : 32'h0;
                end
            end
            if (errs > 0) begin
                exp_flag = 1'b1;
                exp_cnt  = (exp_cnt + errs > 3) ? 3 : exp_cnt + errs;
            end
        end

        if (d_write) begin
            if (new_known) model_mem[d_idx] = new_word;
            else if (model_mem.exists(d_idx)) model_mem.delete(d_idx);
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            if (exp_i_known) checkOutput("model inst_rdata", bus.inst_sram_rdata, exp_inst);
            if (exp_d_known) checkOutput("model data_rdata", bus.data_sram_rdata, exp_data);
            checkOutput("model oor_cnt", 32'(oor_cnt), 32'(exp_cnt));
            checkOutput("model oor_flag", 32'(oor_flag), 32'(exp_flag));
        end
    end

    // Drive one cycle of inputs, then return at the next falling edge with
    // that cycle's results visible on the outputs.
    task automatic applyStimulus(input logic r,
                                 input logic i_en, input logic [3:0] i_wen, input logic [31:0] i_addr,
                                 input logic d_en, input logic [3:0] d_wen, input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata);
        rst                 = r;
        bus.inst_sram_en    = i_en;
        bus.inst_sram_wen   = i_wen;
        bus.inst_sram_addr  = i_addr;
        bus.inst_sram_wdata = $urandom;
        bus.data_sram_en    = d_en;
        bus.data_sram_wen   = d_wen;
        bus.data_sram_addr  = d_addr;
        bus.data_sram_wdata = d_wdata;
        @(negedge clk);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.inst_sram_en    = 1'b0;
        bus.inst_sram_wen   = 4'h0;
        bus.inst_sram_addr  = 32'h0;
        bus.inst_sram_wdata = 32'h0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        @(negedge clk);

        applyStimulus(1, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        checkOutput("reset inst_rdata", bus.inst_sram_rdata, 32'h0);
        checkOutput("reset data_rdata", bus.data_sram_rdata, 32'h0);
        checkOutput("reset oor_cnt", 32'(oor_cnt), 32'h0);
        checkOutput("reset oor_flag", 32'(oor_flag), 32'h0);

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'hF, 32'hBFC0_0010, 32'hDEAD_BEEF);
        checkOutput("write-first data", bus.data_sram_rdata, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 4'h0, 32'hBFC0_0010, 0, 4'h0, 32'h0, 32'h0);
        checkOutput("inst read after write", bus.inst_sram_rdata, 32'hDEAD_BEEF);

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'hF, 32'h9FC0_0020, 32'h1122_3344);
        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'b0101, 32'h9FC0_0020, 32'hAABB_CCDD);
        checkOutput("byte lane merge", bus.data_sram_rdata, 32'h11BB_33DD);

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'hF, 32'h9FC0_0000, 32'hCAFE_F00D);
        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'h0, 32'h9FC0_0003, 32'h0);
        checkOutput("read word 0", bus.data_sram_rdata, 32'hCAFE_F00D);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 4'h0, 32'h0, 0, 4'hF, 32'h9FC0_0100 + 32'(k * 4), 32'h5555_0000 + 32'(k));
            checkOutput("hold while idle", bus.data_sram_rdata, 32'hCAFE_F00D);
        end

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'hF, 32'hBFC0_FFFC, 32'h5A5A_5A5A);
        applyStimulus(0, 1, 4'h0, 32'h9FC0_FFFC, 0, 4'h0, 32'h0, 32'h0);
        checkOutput("last word read", bus.inst_sram_rdata, 32'h5A5A_5A5A);
        checkOutput("last word no error", 32'(oor_cnt), 32'h0);

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'hF, 32'h9FC0_0040, 32'h0);
        applyStimulus(0, 1, 4'h0, 32'hBFC0_0040, 1, 4'hF, 32'h9FC0_0040, 32'h1234_5678);
        checkOutput("collision inst", bus.inst_sram_rdata, FWD_BUILD ? 32'h1234_5678 : 32'h0);
        checkOutput("collision data", bus.data_sram_rdata, 32'h1234_5678);

        applyStimulus(0, 1, 4'h1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_0000, 32'h0);
        checkOutput("oor data read", bus.data_sram_rdata, 32'h0);
        checkOutput("inst wen still reads", bus.inst_sram_rdata, 32'hDEAD_BEEF);
        checkOutput("dual error count", 32'(oor_cnt), 32'd2);
        checkOutput("error flag", 32'(oor_flag), 32'd1);

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'hF, 32'hBFC1_0010, 32'h0);
        applyStimulus(0, 1, 4'h0, 32'hBFC1_0000, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'h0, 32'h0000_0000, 32'h0);
        checkOutput("saturated count", 32'(oor_cnt), 32'd3);
        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'h0, 32'hBFC0_0010, 32'h0);
        checkOutput("oor write dropped", bus.data_sram_rdata, 32'hDEAD_BEEF);

        applyStimulus(0, 0, 4'h0, 32'h0, 1, 4'h0, 32'h9FC0_0020, 32'h0);
        applyStimulus(1, 1, 4'h0, 32'hBFC0_0010, 1, 4'hF, 32'h9FC0_0080, 32'h7777_8888);
        checkOutput("mid reset inst", bus.inst_sram_rdata, 32'h0);
        checkOutput("mid reset data", bus.data_sram_rdata, 32'h0);
        checkOutput("mid reset cnt", 32'(oor_cnt), 32'h0);
        checkOutput("mid reset flag", 32'(oor_flag), 32'h0);
        applyStimulus(0, 1, 4'h0, 32'hBFC0_0020, 1, 4'h0, 32'h9FC0_0080, 32'h0);
        checkOutput("write under reset kept", bus.data_sram_rdata, 32'h7777_8888);
        checkOutput("survives reset", bus.inst_sram_rdata, 32'h11BB_33DD);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 4'h0, 32'hBFC0_0200 + 32'(k * 4), 1, 4'hF,
                          32'h9FC0_0204 + 32'(k * 4), 32'h0101_0101 * 32'(k + 1));
        end
        applyStimulus(0, 1, 4'h0, 32'hBFC0_0220, 0, 4'h0, 32'h0, 32'h0);
        checkOutput("streamed word", bus.inst_sram_rdata, 32'h0808_0808);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
